// File: rtl/imem_loader.sv
// Boot loader: assembles a big-endian word stream into instruction memory writes
// and holds the mips32 core in reset until a complete image has been written.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [7:0]            rxData,
    input  logic                  rxValid,
    output logic [ADDR_WIDTH-1:0] memAddress,
    output logic [31:0]           memData,
    output logic                  memWren,
    output logic                  cpuRst,
    output logic                  busy,
    output logic                  done,
    output logic                  error
);

    localparam int unsigned LEN_W    = 16;
    localparam logic [31:0] CAPACITY = 32'(1) << ADDR_WIDTH;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN_HI,
        S_LEN_LO,
        S_BYTES,
        S_DONE,
        S_ERROR
    } state_t;

    state_t                  state_q, state_nxt;
    logic [LEN_W-1:0]        len_q, len_nxt;
    logic [LEN_W-1:0]        word_q, word_nxt;
    logic [ADDR_WIDTH-1:0]   addr_q, addr_nxt;
    logic [1:0]              idx_q, idx_nxt;
    logic [23:0]             asm_q, asm_nxt;
    logic [ADDR_WIDTH-1:0]   maddr_nxt;
    logic [31:0]             mdata_nxt;
    logic                    wren_nxt, cpurst_nxt, busy_nxt, done_nxt, error_nxt;
    logic [LEN_W-1:0]        len_full;

    assign len_full = {len_q[15:8], rxData};

    // State and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            len_q      <= '0;
            word_q     <= '0;
            addr_q     <= '0;
            idx_q      <= '0;
            asm_q      <= '0;
            memAddress <= '0;
            memData    <= '0;
            memWren    <= 1'b0;
            cpuRst     <= 1'b1;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            len_q      <= len_nxt;
            word_q     <= word_nxt;
            addr_q     <= addr_nxt;
            idx_q      <= idx_nxt;
            asm_q      <= asm_nxt;
            memAddress <= maddr_nxt;
            memData    <= mdata_nxt;
            memWren    <= wren_nxt;
            cpuRst     <= cpurst_nxt;
            busy       <= busy_nxt;
            done       <= done_nxt;
            error      <= error_nxt;
        end
    end

    // Next-state and next-output logic
    always_comb begin
        state_nxt = state_q;
        len_nxt   = len_q;
        word_nxt  = word_q;
        addr_nxt  = addr_q;
        idx_nxt   = idx_q;
        asm_nxt   = asm_q;
        maddr_nxt = memAddress;
        mdata_nxt = memData;
        wren_nxt  = 1'b0;

        case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
                if (start) begin
                    state_nxt = S_LEN_HI;
                    addr_nxt  = '0;
                    idx_nxt   = '0;
                    word_nxt  = '0;
                end
            end
            S_LEN_HI: begin
                if (rxValid) begin
                    len_nxt   = {rxData, len_q[7:0]};
                    state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (rxValid) begin
                    len_nxt = len_full;
                    if (len_full == '0) begin
                        state_nxt = S_DONE;
                    end else if (32'(len_full) > CAPACITY) begin
                        state_nxt = S_ERROR;
                    end else begin
                        state_nxt = S_BYTES;
                    end
                end
            end
            S_BYTES: begin
                if (rxValid) begin
                    asm_nxt = {asm_q[15:0], rxData};
                    idx_nxt = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        mdata_nxt = {asm_q, rxData};
                        maddr_nxt = addr_q;
                        wren_nxt  = 1'b1;
                        word_nxt  = word_q + 16'd1;
                        // Address is not advanced past the final word so it never wraps
                        if (word_q + 16'd1 == len_q) begin
                            state_nxt = S_DONE;
                        end else begin
                            addr_nxt = addr_q + ADDR_WIDTH'(1);
                        end
                    end
                end
            end
            default: state_nxt = S_IDLE;
        endcase

        busy_nxt   = (state_nxt == S_LEN_HI) || (state_nxt == S_LEN_LO) || (state_nxt == S_BYTES);
        done_nxt   = (state_nxt == S_DONE);
        error_nxt  = (state_nxt == S_ERROR);
        // Core release lags done by one cycle so the last write lands first
        cpurst_nxt = !((state_nxt == S_DONE) && done);
    end

endmodule

// File: tb/tb_imem_loader.sv
// Directed vector bench for imem_loader: table-driven stream checks plus
// hand-written async-reset, mid-word reset and full-capacity sequences.
module tb_imem_loader;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  rxData;
    logic        rxValid;
    logic [7:0]  memAddress;
    logic [31:0] memData;
    logic        memWren;
    logic        cpuRst;
    logic        busy;
    logic        done;
    logic        error;

    int checks   = 0;
    int failures = 0;

    imem_loader #(.ADDR_WIDTH(8)) dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .rxData     (rxData),
        .rxValid    (rxValid),
        .memAddress (memAddress),
        .memData    (memData),
        .memWren    (memWren),
        .cpuRst     (cpuRst),
        .busy       (busy),
        .done       (done),
        .error      (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write monitor: records every memory write seen between edges
    logic [31:0] mem_seen [256];
    int          wr_cnt = 0;
    logic [7:0]  last_addr = '0;
    logic [31:0] last_data = '0;
    always @(negedge clk) begin
        if (memWren) begin
            mem_seen[memAddress] = memData;
            last_addr = memAddress;
            last_data = memData;
            wr_cnt++;
        end
    end

    typedef struct packed {
        logic        s;
        logic        v;
        logic [7:0]  d;
        logic [44:0] exp;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [44:0] outs();
        return {memWren, memAddress, memData, busy, done, error, cpuRst};
    endfunction

    function automatic logic [31:0] wval(input int w);
        return {8'(w), 8'(w) ^ 8'h5A, 8'hC3, ~8'(w)};
    endfunction

    task automatic add(input logic s, input logic v, input logic [7:0] d,
                       input logic w, input logic [7:0] a, input logic [31:0] md,
                       input logic b, input logic dn, input logic e, input logic c);
        vec_t x;
        x.s   = s;
        x.v   = v;
        x.d   = d;
        x.exp = {w, a, md, b, dn, e, c};
        tbl.push_back(x);
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    task automatic step(input logic s, input logic v, input logic [7:0] d);
        @(negedge clk);
        start   = s;
        rxValid = v;
        rxData  = d;
        @(posedge clk);
        #1;
    endtask

    localparam logic [44:0] RESET_OUTS = {1'b0, 8'h00, 32'h0, 1'b0, 1'b0, 1'b0, 1'b1};

    initial begin
        int base;
        logic [31:0] w;

        rst = 1'b1; start = 1'b0; rxValid = 1'b0; rxData = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_outputs", 64'(outs()), 64'(RESET_OUTS));
        @(negedge clk);
        rst = 1'b0;
        step(0, 0, 8'h00);
        chk("idle_after_reset", 64'(outs()), 64'(RESET_OUTS));

        // Nominal load with gaps
        add(1,0,8'h00, 0,8'h00,32'h0,        1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h0,        1,0,0,1);
        add(0,1,8'h00, 0,8'h00,32'h0,        1,0,0,1);
        add(0,1,8'h02, 0,8'h00,32'h0,        1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h0,        1,0,0,1);
        add(0,1,8'h12, 0,8'h00,32'h0,        1,0,0,1);
        add(0,1,8'h34, 0,8'h00,32'h0,        1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h0,        1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h0,        1,0,0,1);
        add(0,1,8'h56, 0,8'h00,32'h0,        1,0,0,1);
        add(0,1,8'h78, 1,8'h00,32'h12345678, 1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,1,8'hAA, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,1,8'hBB, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,0,8'h00, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,1,8'hCC, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,1,8'hDD, 1,8'h01,32'hAABBCCDD, 0,1,0,1);
        add(0,0,8'h00, 0,8'h01,32'hAABBCCDD, 0,1,0,0);
        add(0,0,8'h00, 0,8'h01,32'hAABBCCDD, 0,1,0,0);
        // Streaming, start pulses mid-stream ignored
        add(1,0,8'h00, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h00, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h02, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h12, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h34, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(1,1,8'h56, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h78, 1,8'h00,32'h12345678, 1,0,0,1);
        add(0,1,8'hAA, 0,8'h00,32'h12345678, 1,0,0,1);
        add(1,1,8'hBB, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,1,8'hCC, 0,8'h00,32'h12345678, 1,0,0,1);
        add(0,1,8'hDD, 1,8'h01,32'hAABBCCDD, 0,1,0,1);
        add(0,0,8'h00, 0,8'h01,32'hAABBCCDD, 0,1,0,0);
        // Zero length; rxValid alongside start is ignored
        add(1,1,8'hFF, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h00, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h00, 0,8'h01,32'hAABBCCDD, 0,1,0,1);
        add(0,0,8'h00, 0,8'h01,32'hAABBCCDD, 0,1,0,0);
        add(0,1,8'h55, 0,8'h01,32'hAABBCCDD, 0,1,0,0);
        // Overflow then recovery
        add(1,0,8'h00, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h01, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h01, 0,8'h01,32'hAABBCCDD, 0,0,1,1);
        add(0,1,8'h00, 0,8'h01,32'hAABBCCDD, 0,0,1,1);
        add(0,0,8'h00, 0,8'h01,32'hAABBCCDD, 0,0,1,1);
        add(1,0,8'h00, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h00, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'h01, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'hDE, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'hAD, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'hBE, 0,8'h01,32'hAABBCCDD, 1,0,0,1);
        add(0,1,8'hEF, 1,8'h00,32'hDEADBEEF, 0,1,0,1);
        add(0,0,8'h00, 0,8'h00,32'hDEADBEEF, 0,1,0,0);

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].s, tbl[i].v, tbl[i].d);
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(tbl[i].exp));
        end

        // Asynchronous reset between edges while the core is running
        @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("async_reset_outs", 64'(outs()), 64'(RESET_OUTS));
        @(negedge clk);
        rst = 1'b0;
        base = wr_cnt;
        step(0, 0, 8'h00);
        step(0, 1, 8'hAB);
        step(0, 0, 8'h00);
        chk("idle_no_start", 64'(outs()), 64'(RESET_OUTS));
        chk("idle_no_writes", 64'(wr_cnt - base), 64'(0));

        // Reset mid-word discards the partial word
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h11);
        step(0, 1, 8'h22);
        @(negedge clk);
        rxValid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        chk("midword_reset_outs", 64'(outs()), 64'(RESET_OUTS));
        @(negedge clk);
        rst = 1'b0;
        base = wr_cnt;
        step(1, 0, 8'h00);
        step(0, 1, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h33);
        step(0, 1, 8'h44);
        step(0, 1, 8'h55);
        step(0, 1, 8'h66);
        chk("reload_outs", 64'(outs()),
            64'({1'b1, 8'h00, 32'h33445566, 1'b0, 1'b1, 1'b0, 1'b1}));
        step(0, 0, 8'h00);
        chk("reload_single_write", 64'(wr_cnt - base), 64'(1));
        chk("reload_data", 64'({last_addr, last_data}), 64'({8'h00, 32'h33445566}));

        // Full capacity: N = 256 is legal and fills every address back-to-back
        step(1, 0, 8'h00);
        step(0, 1, 8'h01);
        step(0, 1, 8'h00);
        chk("cap_accepted", 64'({busy, error}), 64'({1'b1, 1'b0}));
        base = wr_cnt;
        for (int wi = 0; wi < 256; wi++) begin
            w = wval(wi);
            for (int b = 0; b < 4; b++) begin
                step(0, 1, w[31-8*b -: 8]);
            end
        end
        chk("cap_done", 64'({done, busy, error, cpuRst, memAddress}),
            64'({1'b1, 1'b0, 1'b0, 1'b1, 8'hFF}));
        step(0, 0, 8'h00);
        chk("cap_cpu_release", 64'({done, cpuRst}), 64'({1'b1, 1'b0}));
        chk("cap_write_count", 64'(wr_cnt - base), 64'(256));
        for (int i = 0; i < 256; i++) begin
            chk($sformatf("cap_mem%0d", i), 64'(mem_seen[i]), 64'(wval(i)));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
